// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC relay sequencer: state encoding, STC word
// bit positions and timer sizing helpers.
package hvac_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEAT    = 3'd1,
      S_COOL    = 3'd2,
      S_OVERRUN = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   localparam int STC_HEAT_EN    = 18;
   localparam int STC_COOL_EN    = 17;
   localparam int STC_FAN_REQ    = 16;
   localparam int STC_COOL_SP_HI = 15;
   localparam int STC_COOL_SP_LO = 8;
   localparam int STC_HEAT_SP_HI = 7;
   localparam int STC_HEAT_SP_LO = 0;

   // A timer holding up to max_count-1 needs $clog2(max_count) bits, never fewer than 1.
   function automatic int timer_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

   // Done is the zero count, so an N-cycle interval loads N-1 (and 0 stays 0).
   function automatic int load_value(input int cycles);
      return (cycles > 0) ? cycles - 1 : 0;
   endfunction

endpackage

// File: rtl/hvac_timer.sv
// Load-value down-counter that saturates at zero; done while the count is zero.
module hvac_timer #(
   parameter int             W           = 8,
   parameter logic [W-1:0]   RESET_VALUE = '0
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_done
);

   logic [W-1:0] count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count <= RESET_VALUE;
      end else if (i_load) begin
         count <= i_value;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign o_done = (count == '0);

endmodule

// File: rtl/hvac_relay_ctrl.sv
// Heat/cool/fan relay sequencer with hysteresis, compressor min-on/min-off
// protection and a fan overrun after each run.
module hvac_relay_ctrl
   import hvac_pkg::*;
#(
   parameter int g_clk_freq      = 50,
   parameter int g_min_on_s      = 2,
   parameter int g_min_off_s     = 3,
   parameter int g_fan_overrun_s = 1,
   parameter int g_hyst          = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_stc,
   input  logic [8:0]  i_temp,
   output logic        o_heat,
   output logic        o_cool,
   output logic        o_fan,
   output logic [2:0]  o_state
);

   localparam int ON_CYC  = g_min_on_s * g_clk_freq;
   localparam int OVR_CYC = g_fan_overrun_s * g_clk_freq;
   localparam int OFF_CYC = g_min_off_s * g_clk_freq;
   localparam int MAX_A   = (ON_CYC > OVR_CYC) ? ON_CYC : OVR_CYC;
   localparam int MAX_CYC = (MAX_A > OFF_CYC) ? MAX_A : OFF_CYC;
   localparam int TW      = timer_width(MAX_CYC);

   localparam logic [TW-1:0] ON_LOAD  = TW'(load_value(ON_CYC));
   localparam logic [TW-1:0] OVR_LOAD = TW'(load_value(OVR_CYC));
   localparam logic [TW-1:0] OFF_LOAD = TW'(load_value(OFF_CYC));
   localparam logic [8:0]    HYST9    = 9'(g_hyst);

   state_t     state, state_nx;
   logic       heat_en, cool_en, fan_req;
   logic [8:0] t9, heat_sp9, cool_sp9;
   logic       heat_start, heat_stop, cool_start, cool_stop;
   logic       on_load, ovr_load, off_load;
   logic       on_done, ovr_done, off_done;
   logic       unused_bits;

   assign heat_en  = i_stc[STC_HEAT_EN];
   assign cool_en  = i_stc[STC_COOL_EN];
   assign fan_req  = i_stc[STC_FAN_REQ];
   assign heat_sp9 = {1'b0, i_stc[STC_HEAT_SP_HI:STC_HEAT_SP_LO]};
   assign cool_sp9 = {1'b0, i_stc[STC_COOL_SP_HI:STC_COOL_SP_LO]};
   // Temperature carries one more fractional bit than the setpoints; drop it.
   assign t9       = {1'b0, i_temp[8:1]};
   assign unused_bits = ^{i_stc[31:19], i_temp[0]};

   assign heat_start = heat_en && (t9 < heat_sp9);
   assign heat_stop  = !heat_en || (t9 >= heat_sp9 + HYST9);
   assign cool_start = cool_en && (t9 > cool_sp9);
   assign cool_stop  = !cool_en || (t9 + HYST9 <= cool_sp9);

   always_comb begin
      state_nx = state;
      on_load  = 1'b0;
      ovr_load = 1'b0;
      off_load = 1'b0;
      case (state)
         S_IDLE: begin
            if (heat_start) begin
               state_nx = S_HEAT;
               on_load  = 1'b1;
            end else if (cool_start) begin
               state_nx = S_COOL;
               on_load  = 1'b1;
            end
         end
         S_HEAT, S_COOL: begin
            if (on_done && ((state == S_HEAT) ? heat_stop : cool_stop)) begin
               state_nx = S_OVERRUN;
               ovr_load = 1'b1;
               off_load = 1'b1;
            end
         end
         S_OVERRUN: begin
            if (ovr_done) begin
               state_nx = off_done ? S_IDLE : S_LOCKOUT;
            end
         end
         S_LOCKOUT: begin
            if (off_done) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_LOCKOUT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state  <= S_LOCKOUT;
         o_heat <= 1'b0;
         o_cool <= 1'b0;
         o_fan  <= 1'b0;
      end else begin
         state  <= state_nx;
         o_heat <= (state_nx == S_HEAT);
         o_cool <= (state_nx == S_COOL);
         o_fan  <= (state_nx inside {S_HEAT, S_COOL, S_OVERRUN}) || fan_req;
      end
   end

   assign o_state = state;

   hvac_timer #(.W(TW), .RESET_VALUE('0)) u_on_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (on_load),
      .i_value (ON_LOAD),
      .o_done  (on_done)
   );

   hvac_timer #(.W(TW), .RESET_VALUE('0)) u_ovr_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (ovr_load),
      .i_value (OVR_LOAD),
      .o_done  (ovr_done)
   );

   // Reset preloads the off-timer so power-up also honours min-off.
   hvac_timer #(.W(TW), .RESET_VALUE(OFF_LOAD)) u_off_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (off_load),
      .i_value (OFF_LOAD),
      .o_done  (off_done)
   );

endmodule

// File: doc/hvac_relay_ctrl.md
# hvac_relay_ctrl

Relay-sequencing stage directly downstream of `usr_ctrl_ovride`. It consumes the settled 32-bit STC word and the measured temperature, and decides when to drive the heat, cool and fan relays. Decisions use hysteresis, a compressor minimum on-time and minimum off-time, and a post-run fan overrun. Its outputs drive the relay driver pins at the top level.

## Interface
- `g_clk_freq`, 50: clock cycles per second.
- `g_min_on_s`, 2: minimum seconds heat/cool stays on once started.
- `g_min_off_s`, 3: minimum seconds between equipment stop (or reset) and the next start.
- `g_fan_overrun_s`, 1: seconds the fan runs after heat/cool stops.
- `g_hyst`, 1: hysteresis in setpoint LSBs (0.5 degree each).
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_stc`  in  32  settled STC word: [18] heat_en, [17] cool_en, [16] fan_req, [15:8] cool_sp ufixed(6 downto -1), [7:0] heat_sp ufixed(6 downto -1), remaining bits ignored.
- `i_temp`  in  9  measured temperature, ufixed(6 downto -2), same unit as setpoints.
- `o_heat`  out  1  heat relay.
- `o_cool`  out  1  cool relay.
- `o_fan`  out  1  fan relay.
- `o_state`  out  3  current FSM state, for debug and the UI.

## Operation
- Compare value `t = i_temp[8:1]` (quarter-degree bit dropped). All sums are 9-bit, so nothing wraps.
- Heat start: `heat_en && t < heat_sp`.
- Heat stop: `!heat_en || t >= heat_sp + g_hyst`.
- Cool start: `cool_en && t > cool_sp`.
- Cool stop: `!cool_en || t + g_hyst <= cool_sp`.
- States: S_IDLE=0, S_HEAT=1, S_COOL=2, S_OVERRUN=3, S_LOCKOUT=4.
- S_IDLE:
  - heat start -> S_HEAT.
  - Otherwise, cool start -> S_COOL.
  - If both are true in the same cycle (heat_sp > cool_sp), heat wins.
- S_HEAT / S_COOL: on-timer loads `g_min_on_s*g_clk_freq` on entry. Exit to S_OVERRUN only when the on-timer is done and the stop condition is true.
  - The stop condition is ignored before min-on expires, including loss of enable.
  - No direct HEAT<->COOL transition.
- Entry to S_OVERRUN:
  - Overrun timer loads `g_fan_overrun_s*g_clk_freq`.
  - Off-timer loads `g_min_off_s*g_clk_freq`.
- S_OVERRUN: when the overrun timer is done, go to S_IDLE if the off-timer is done, else S_LOCKOUT. The off-timer keeps counting during overrun.
- S_LOCKOUT: go to S_IDLE when the off-timer is done. No start is possible in this state.
- Relay decode:
  - `o_heat` = S_HEAT.
  - `o_cool` = S_COOL.
  - `o_fan` = S_HEAT | S_COOL | S_OVERRUN | fan_req.
- Heat and cool are never asserted together.
- A timer parameter of 0 means done on the first cycle after load.

## Timing
- Reset (any cycle, including mid-heat/cool):
  - Next cycle: state S_LOCKOUT, off-timer loaded with the full min-off count, on/overrun timers cleared.
  - All relay outputs 0, `o_state`=4.
  - Power-up and reset therefore always enforce min-off.
- State register and outputs are registered. A start condition sampled true at edge N gives a relay high from edge N+1.
- Min-on: a relay entering at edge N cannot drop before edge `N + g_min_on_s*g_clk_freq`. It drops exactly at that edge if the stop condition is already true in the preceding cycle.
- Overrun: fan-only for exactly `g_fan_overrun_s*g_clk_freq` cycles.
- Next start is at the earliest `g_min_off_s*g_clk_freq` cycles after the relay dropped.
- `i_stc` and `i_temp` are sampled every cycle with no internal synchronizers; both are in the `i_clk` domain.

## Structure
- Package `hvac_pkg`:
  - State encoding constants.
  - STC bit-position constants (HEAT_EN=18, COOL_EN=17, FAN_REQ=16, cool_sp and heat_sp ranges), shared with `usr_ctrl_ovride`.
  - Timer width function based on `$clog2`.
- Sub-module `hvac_timer`, instantiated three times (on, overrun, off):
  - Load-value down-counter.
  - Ports: `i_clk`, `i_reset`, `i_load`, `i_value`, `o_done`.
  - Saturates at 0.
  - Done is high when the count is 0.

## Test plan
Default parameters; min-on 100, overrun 50, min-off 150 cycles.

- Reset release, `i_stc`=0x4002C (heat_en, heat_sp=22.0), `i_temp`=0x054 (21.0) -> S_LOCKOUT for 150 cycles, then `o_heat`=1 and `o_fan`=1 one cycle after S_IDLE.
- While heating, raise `i_temp` to 0x05A (22.5) at cycle 20 of heat -> `o_heat` holds until cycle 100 of heat, then S_OVERRUN with `o_fan` only for 50 cycles, then S_LOCKOUT for 100, then S_IDLE.
- `i_stc`=0x62C2C (auto, both setpoints 22.0) with `i_temp`=0x054 -> `o_heat`=1, `o_cool` stays 0 throughout.
- Clear cool_en at cycle 10 of a cool run -> `o_cool` remains 1 until cycle 100.
- Assert `i_reset` mid-cool -> next cycle all relays 0, `o_state`=4; a restart waits the full 150 cycles.
- fan_req=1 (`i_stc`=0x10000) in S_IDLE -> `o_fan`=1 with `o_heat`=`o_cool`=0; clear fan_req -> `o_fan`=0 next cycle.
